// File: rtl/ysyx_23060077_lsu_sram_pkg.sv
// Shared definitions for the LSU-side SRAM responder and its lane aligner.
package ysyx_23060077_lsu_sram_pkg;

    // Access size codes as driven by the LSU on lsu_*_size_i
    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    // Width of the latency countdown; wide enough for LATENCY up to 15
    localparam int CNT_W = 4;

    // Responder states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Any size code above a word is not a legal access
    function automatic logic size_illegal(input logic [2:0] size);
        return size > SIZE_W;
    endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_lane_align.sv
// Byte-lane alignment for single-beat 32-bit accesses: shifts write data
// into its lanes, builds the byte strobe, right-justifies and masks read
// data, and flags half/word accesses that straddle their natural boundary.
module ysyx_23060077_lsu_lane_align
    import ysyx_23060077_lsu_sram_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [31:0] wdata_shift,
    output logic [3:0]  strobe,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [4:0]  shamt;
    logic [31:0] rdata_shift;

    assign shamt = {addr_lo, 3'b000};

    // Lane steering and size masking; illegal sizes produce no strobe and no data
    always_comb begin
        wdata_shift = wdata << shamt;
        rdata_shift = rdata_word >> shamt;
        strobe      = 4'b0000;
        rdata       = '0;
        misalign    = 1'b0;
        case (size)
            SIZE_B: begin
                strobe = 4'b0001 << addr_lo;
                rdata  = {24'b0, rdata_shift[7:0]};
            end
            SIZE_H: begin
                strobe   = 4'b0011 << addr_lo;
                rdata    = {16'b0, rdata_shift[15:0]};
                misalign = addr_lo[0];
            end
            SIZE_W: begin
                strobe   = 4'b1111;
                rdata    = rdata_shift;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                strobe = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060077_lsu_sram.sv
// Memory-side responder for the LSU request interface. One request at a time
// is accepted in IDLE (read wins over write), the array is accessed on the
// acceptance edge, and a single response pulse follows LATENCY cycles later.
module ysyx_23060077_lsu_sram
    import ysyx_23060077_lsu_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    LATENCY     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lsu_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_r_addr_i,
    input  logic [2:0]            lsu_r_size_i,
    input  logic [7:0]            lsu_r_len_i,
    output logic                  lsu_r_ready_o,
    output logic                  lsu_r_last_o,
    output logic [DATA_WIDTH-1:0] lsu_r_data_o,
    input  logic                  lsu_w_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_w_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
    input  logic [2:0]            lsu_w_size_i,
    input  logic [7:0]            lsu_w_len_i,
    output logic                  lsu_w_ready_o,
    output logic                  lsu_w_last_o,
    output logic                  resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Array size in bytes, two bits wider than an address so it never overflows
    localparam logic [ADDR_WIDTH+1:0] DEPTH_BYTES = (ADDR_WIDTH+2)'(DEPTH_WORDS) << 2;

    lsu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept;
    logic in_resp;

    logic                  sel_read;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] offset;
    logic [2:0]            req_size;
    logic [7:0]            req_len;
    logic                  in_range;
    logic                  req_err;
    logic [IDX_W-1:0]      word_idx;

    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] rdata_word;
    logic [DATA_WIDTH-1:0] rdata_aligned;
    logic [3:0]            strobe;
    logic                  misalign;

    logic                  is_read_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rd_hold_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // The request presented to the array is the read when one is pending,
    // otherwise the write; only meaningful in the cycle it is accepted.
    assign sel_read = lsu_r_valid_i;
    assign req_addr = sel_read ? lsu_r_addr_i : lsu_w_addr_i;
    assign req_size = sel_read ? lsu_r_size_i : lsu_w_size_i;
    assign req_len  = sel_read ? lsu_r_len_i  : lsu_w_len_i;

    // Wrap below BASE_ADDR yields a huge offset, but the explicit compare
    // keeps the range check honest regardless of DEPTH_WORDS.
    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && ({2'b00, offset} < DEPTH_BYTES);
    assign word_idx = offset[IDX_W+1:2];
    assign req_err  = size_illegal(req_size) || (req_len != 8'd0) || misalign || !in_range;

    assign rdata_word = mem[word_idx];

    ysyx_23060077_lsu_lane_align u_lane_align (
        .addr_lo     (req_addr[1:0]),
        .size        (req_size),
        .wdata       (lsu_w_data_i),
        .rdata_word  (rdata_word),
        .wdata_shift (wdata_shift),
        .strobe      (strobe),
        .rdata       (rdata_aligned),
        .misalign    (misalign)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, pulse once in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (lsu_r_valid_i || lsu_w_valid_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, countdown and response bookkeeping; the read result is captured
    // at acceptance and published into the held data register at the response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            err_q     <= 1'b0;
            rd_hold_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_read_q <= sel_read;
                err_q     <= req_err;
                rd_hold_q <= (sel_read && !req_err) ? rdata_aligned : '0;
            end
            if (in_resp && is_read_q) begin
                rdata_q <= rd_hold_q;
            end
        end
    end

    // Array write commits on the acceptance edge; the array itself is never reset
    always_ff @(posedge clock) begin
        if (reset && accept && !sel_read && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_shift[8*b +: 8];
                end
            end
        end
    end

    assign in_resp       = (state_q == ST_RESP);
    assign lsu_r_ready_o = in_resp && is_read_q;
    assign lsu_r_last_o  = in_resp && is_read_q;
    assign lsu_w_ready_o = in_resp && !is_read_q;
    assign lsu_w_last_o  = in_resp && !is_read_q;
    assign resp_err_o    = in_resp && err_q;
    assign lsu_r_data_o  = (in_resp && is_read_q) ? rd_hold_q : rdata_q;

endmodule

// File: tb/tb_ysyx_23060077_lsu_sram.sv
// Self-checking bench for the LSU SRAM responder: a byte-level memory model
// and a response schedule predict every output cycle, with literal pins on
// the directed scenarios and two extra instances for latency extremes.
module tb_ysyx_23060077_lsu_sram;

    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    typedef struct {
        int          cyc;
        bit          is_read;
        bit          err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        r_valid, r_ready, r_last;
    logic [31:0] r_addr, r_data;
    logic [2:0]  r_size;
    logic [7:0]  r_len;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_addr, w_data;
    logic [2:0]  w_size;
    logic [7:0]  w_len;
    logic        resp_err;

    logic        ax_r_valid;
    logic [31:0] ax_r_addr;
    logic        a1_r_ready, a1_r_last, a1_w_ready, a1_w_last, a1_err;
    logic [31:0] a1_r_data;
    logic        a15_r_ready, a15_r_last, a15_w_ready, a15_w_last, a15_err;
    logic [31:0] a15_r_data;

    int          cyc = 0;
    bit          check_en = 1'b0;
    int          total_checks = 0;
    int          passed_checks = 0;
    resp_t       exp_q[$];
    logic [31:0] model_rdata = '0;
    logic [31:0] mmem [DEPTH];

    always #5 clk = ~clk;

    ysyx_23060077_lsu_sram #(.LATENCY(LAT)) dut (
        .clock(clk), .reset(rst),
        .lsu_r_valid_i(r_valid), .lsu_r_addr_i(r_addr), .lsu_r_size_i(r_size), .lsu_r_len_i(r_len),
        .lsu_r_ready_o(r_ready), .lsu_r_last_o(r_last), .lsu_r_data_o(r_data),
        .lsu_w_valid_i(w_valid), .lsu_w_addr_i(w_addr), .lsu_w_data_i(w_data),
        .lsu_w_size_i(w_size), .lsu_w_len_i(w_len),
        .lsu_w_ready_o(w_ready), .lsu_w_last_o(w_last), .resp_err_o(resp_err)
    );

    ysyx_23060077_lsu_sram #(.LATENCY(1)) dut_lat1 (
        .clock(clk), .reset(rst),
        .lsu_r_valid_i(ax_r_valid), .lsu_r_addr_i(ax_r_addr), .lsu_r_size_i(3'd2), .lsu_r_len_i(8'd0),
        .lsu_r_ready_o(a1_r_ready), .lsu_r_last_o(a1_r_last), .lsu_r_data_o(a1_r_data),
        .lsu_w_valid_i(1'b0), .lsu_w_addr_i(32'd0), .lsu_w_data_i(32'd0),
        .lsu_w_size_i(3'd0), .lsu_w_len_i(8'd0),
        .lsu_w_ready_o(a1_w_ready), .lsu_w_last_o(a1_w_last), .resp_err_o(a1_err)
    );

    ysyx_23060077_lsu_sram #(.LATENCY(15)) dut_lat15 (
        .clock(clk), .reset(rst),
        .lsu_r_valid_i(ax_r_valid), .lsu_r_addr_i(ax_r_addr), .lsu_r_size_i(3'd2), .lsu_r_len_i(8'd0),
        .lsu_r_ready_o(a15_r_ready), .lsu_r_last_o(a15_r_last), .lsu_r_data_o(a15_r_data),
        .lsu_w_valid_i(1'b0), .lsu_w_addr_i(32'd0), .lsu_w_data_i(32'd0),
        .lsu_w_size_i(3'd0), .lsu_w_len_i(8'd0),
        .lsu_w_ready_o(a15_w_ready), .lsu_w_last_o(a15_w_last), .resp_err_o(a15_err)
    );

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Byte-level reference: decide legality from the access rules, then move
    // bytes one address at a time between the bus value and the model memory.
    function automatic void model_access(input bit is_read, input logic [31:0] addr,
                                         input logic [2:0] size, input logic [7:0] len,
                                         input logic [31:0] wdata,
                                         output bit err, output logic [31:0] data);
        longint off;
        longint a;
        int     nb;
        int     w;
        int     b;
        off  = longint'(addr) - longint'(BASE);
        err  = 1'b0;
        data = '0;
        nb   = 1;
        if (size > 3'd2 || len != 8'd0) begin
            err = 1'b1;
        end else begin
            nb = 1 << size;
            if ((addr % nb) != 0) err = 1'b1;
            if (off < 0 || off >= 4 * DEPTH) err = 1'b1;
        end
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                a = off + i;
                w = int'(a / 4);
                b = int'(a % 4);
                if (is_read) data[8*i +: 8] = mmem[w][8*b +: 8];
                else         mmem[w][8*b +: 8] = wdata[8*i +: 8];
            end
        end
    endfunction

    // Cycle counter; a sampled reset discards every scheduled response
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            model_rdata = '0;
        end
    end

    // Every cycle, the main instance's outputs must match the schedule
    always @(negedge clk) begin : compare_proc
        resp_t       r;
        logic [36:0] exp_vec;
        if (check_en) begin
            exp_vec = {5'b0, model_rdata};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                r = exp_q.pop_front();
                if (r.is_read) model_rdata = r.data;
                exp_vec = {r.is_read, r.is_read, !r.is_read, !r.is_read, r.err, model_rdata};
            end
            check_output("cycle_outputs",
                         {27'b0, r_ready, r_last, w_ready, w_last, resp_err, r_data},
                         {27'b0, exp_vec});
        end
    end

    // One request on the main instance; returns what the response pulse carried
    task automatic apply_stimulus(input bit is_read, input logic [31:0] addr,
                                  input logic [2:0] size, input logic [7:0] len,
                                  input logic [31:0] wdata,
                                  output logic [31:0] got_data, output logic got_err,
                                  output int got_lat);
        resp_t r;
        bit    seen;
        int    c0;
        seen     = 1'b0;
        got_data = '0;
        got_err  = 1'b0;
        got_lat  = -1;
        c0       = cyc;
        model_access(is_read, addr, size, len, wdata, r.err, r.data);
        r.is_read = is_read;
        r.cyc     = c0 + LAT;
        exp_q.push_back(r);
        if (is_read) begin
            r_addr = addr; r_size = size; r_len = len; r_valid = 1'b1;
        end else begin
            w_addr = addr; w_size = size; w_len = len; w_data = wdata; w_valid = 1'b1;
        end
        for (int i = 0; i < LAT + 4 && !seen; i++) begin
            @(negedge clk);
            if ((is_read && r_ready) || (!is_read && w_ready)) begin
                seen     = 1'b1;
                got_data = r_data;
                got_err  = resp_err;
                got_lat  = cyc - c0;
            end
        end
        check_output("handshake", {63'b0, seen}, 64'd1);
        @(posedge clk); #1;
        r_valid = 1'b0;
        w_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] d;
        logic        e;
        int          l;
        int          c0, rp, wp, aux_bad;
        logic [31:0] rd, a;
        logic [2:0]  sz;
        logic [7:0]  ln;
        bit          is_rd, mb;
        logic [31:0] md;
        resp_t       r;
        int          p1[$];
        int          p15[$];

        r_valid = 0; r_addr = 0; r_size = 0; r_len = 0;
        w_valid = 0; w_addr = 0; w_data = 0; w_size = 0; w_len = 0;
        ax_r_valid = 0; ax_r_addr = 0;

        @(posedge clk); #1;
        check_en = 1'b1;
        @(negedge clk);
        check_output("reset_state", {27'b0, r_ready, r_last, w_ready, w_last, resp_err, r_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Known contents for the word windows the random phase touches
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, BASE + 32'(4 * ((i < 16) ? i : 1004 + i)), 3'd2, 8'd0, $urandom, d, e, l);
        end

        $display("[TB] word write/read");
        apply_stimulus(1'b0, BASE + 32'h10, 3'd2, 8'd0, 32'hDEADBEEF, d, e, l);
        check_output("tp1_write_err", {63'b0, e}, 64'd0);
        check_output("tp1_write_latency", l, 2);
        apply_stimulus(1'b1, BASE + 32'h10, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp1_read_data", d, 32'hDEADBEEF);
        check_output("tp1_read_latency", l, 2);

        $display("[TB] byte/half lanes");
        apply_stimulus(1'b0, BASE + 32'h10, 3'd2, 8'd0, 32'h11223344, d, e, l);
        apply_stimulus(1'b0, BASE + 32'h13, 3'd0, 8'd0, 32'h000000AA, d, e, l);
        apply_stimulus(1'b1, BASE + 32'h10, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp2_word", d, 32'hAA223344);
        apply_stimulus(1'b1, BASE + 32'h12, 3'd1, 8'd0, 32'h0, d, e, l);
        check_output("tp2_half", d, 32'h0000AA22);
        apply_stimulus(1'b1, BASE + 32'h11, 3'd0, 8'd0, 32'h0, d, e, l);
        check_output("tp2_byte", d, 32'h00000033);

        $display("[TB] misalign and range");
        apply_stimulus(1'b1, BASE + 32'h2, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp3_misalign", {31'b0, e, d}, {31'b0, 1'b1, 32'h0});
        apply_stimulus(1'b0, 32'h7FFF_FFFC, 3'd2, 8'd0, 32'h12345678, d, e, l);
        check_output("tp3_below_base", {63'b0, e}, 64'd1);
        apply_stimulus(1'b0, BASE + 32'd4096, 3'd2, 8'd0, 32'h12345678, d, e, l);
        check_output("tp3_above_top", {63'b0, e}, 64'd1);
        apply_stimulus(1'b1, BASE + 32'h10, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp3_unchanged", d, 32'hAA223344);

        $display("[TB] simultaneous read and write");
        c0 = cyc;
        model_access(1'b1, BASE + 32'h10, 3'd2, 8'd0, 32'h0, mb, md);
        r.cyc = c0 + LAT; r.is_read = 1'b1; r.err = mb; r.data = md;
        exp_q.push_back(r);
        model_access(1'b0, BASE + 32'h10, 3'd2, 8'd0, 32'h55667788, mb, md);
        r.cyc = c0 + 2 * LAT + 1; r.is_read = 1'b0; r.err = mb; r.data = md;
        exp_q.push_back(r);
        r_addr = BASE + 32'h10; r_size = 3'd2; r_len = 8'd0; r_valid = 1'b1;
        w_addr = BASE + 32'h10; w_size = 3'd2; w_len = 8'd0; w_data = 32'h55667788; w_valid = 1'b1;
        rp = -1; wp = -1; rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (r_ready) begin rp = cyc - c0; rd = r_data; end
            if (rp >= 0) break;
        end
        @(posedge clk); #1;
        r_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (w_ready) wp = cyc - c0;
            if (wp >= 0) break;
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
        check_output("tp4_read_cycle", rp, 2);
        check_output("tp4_write_cycle", wp, 5);
        check_output("tp4_read_old_data", rd, 32'hAA223344);
        apply_stimulus(1'b1, BASE + 32'h10, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp4_write_landed", d, 32'h55667788);

        $display("[TB] latency extremes with held valid");
        c0 = cyc; aux_bad = 0;
        ax_r_addr = 32'h0; ax_r_valid = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (a1_r_ready) begin
                p1.push_back(cyc - c0);
                if (!(a1_r_last && a1_err && a1_r_data == 32'h0 && !a1_w_ready && !a1_w_last)) aux_bad++;
            end
            if (a15_r_ready) begin
                p15.push_back(cyc - c0);
                if (!(a15_r_last && a15_err && a15_r_data == 32'h0 && !a15_w_ready && !a15_w_last)) aux_bad++;
            end
        end
        @(posedge clk); #1;
        ax_r_valid = 1'b0;
        check_output("lat1_first",   (p1.size()  > 0) ? p1[0]  : -1, 1);
        check_output("lat1_second",  (p1.size()  > 1) ? p1[1]  : -1, 3);
        check_output("lat15_first",  (p15.size() > 0) ? p15[0] : -1, 15);
        check_output("lat15_second", (p15.size() > 1) ? p15[1] : -1, 31);
        check_output("lat_pulse_fields", aux_bad, 0);

        $display("[TB] reset during wait");
        model_access(1'b0, BASE + 32'h20, 3'd2, 8'd0, 32'hCAFEF00D, mb, md);
        w_addr = BASE + 32'h20; w_size = 3'd2; w_len = 8'd0; w_data = 32'hCAFEF00D; w_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        w_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_output("tp6_abort_outputs", {27'b0, r_ready, r_last, w_ready, w_last, resp_err, r_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        apply_stimulus(1'b1, BASE + 32'h20, 3'd2, 8'd0, 32'h0, d, e, l);
        check_output("tp6_committed", d, 32'hCAFEF00D);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 150; n++) begin
            is_rd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: begin
                    case ($urandom_range(0, 4))
                        0:       a = BASE - 32'd4;
                        1:       a = BASE - 32'd1;
                        2:       a = BASE + 32'd4096;
                        3:       a = 32'h0;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
                1, 2:    a = BASE + 32'(4 * $urandom_range(1020, 1023)) + 32'($urandom_range(0, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ln = ($urandom_range(0, 14) == 0) ? 8'd1 : 8'd0;
            apply_stimulus(is_rd, a, sz, ln, $urandom, d, e, l);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_lsu_sram.md
Name: ysyx_23060077_lsu_sram

Overview:
Memory-side responder for the LSU load/store request interface. It accepts a single-beat read or write request from the LSU, waits a configurable latency, and returns one response pulse. The block performs byte-lane alignment and strobing against an internal word-addressed SRAM array. It serves as the LSU's bench/sim memory and as the template for the responder end inside the AXI bridge.

Parameters:
DATA_WIDTH, 32, data bus width; fixed at 32 for this revision.
ADDR_WIDTH, 32, request address width.
DEPTH_WORDS, 1024, number of 32-bit words in the array.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
lsu_r_valid_i  in  1  read request pending; held high until response
lsu_r_addr_i  in  32  read byte address
lsu_r_size_i  in  3  0=byte, 1=half, 2=word; other values are an error
lsu_r_len_i  in  8  beats-1; only 0 is supported
lsu_r_ready_o  out  1  read response valid (one-cycle pulse)
lsu_r_last_o  out  1  asserted together with lsu_r_ready_o
lsu_r_data_o  out  32  read data, right-justified (addressed byte in [7:0])
lsu_w_valid_i  in  1  write request pending; held high until response
lsu_w_addr_i  in  32  write byte address
lsu_w_data_i  in  32  write data, right-justified (unshifted)
lsu_w_size_i  in  3  same encoding as lsu_r_size_i
lsu_w_len_i  in  8  only 0 is supported
lsu_w_ready_o  out  1  write response (one-cycle pulse)
lsu_w_last_o  out  1  asserted together with lsu_w_ready_o
resp_err_o  out  1  qualifies the current response pulse as an error

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge): state goes to IDLE, counter clears, and all outputs go to 0. The array is not cleared.
  - Reset asserted mid-operation aborts the transaction. Any write already committed stays committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If lsu_r_valid_i=1, accept the read.
  - Otherwise, if lsu_w_valid_i=1, accept the write. Read has priority when both are high; the write stays pending.
  - On acceptance, latch type, addr, size, len and wdata.
  - Go to RESP if LATENCY==1, else go to WAIT with cnt=LATENCY-2.
- WAIT: decrement cnt; when cnt==0, go to RESP.
- RESP:
  - Drive ready=last=1 on the accepted channel only; the other channel's outputs stay 0.
  - Drive resp_err_o and lsu_r_data_o.
  - Next state is always IDLE.
  - lsu_r_data_o holds its value until the next read response; it is 0 after reset.
- Latency: valid first high in IDLE at cycle t gives the response pulse in cycle t+LATENCY.
- Turnaround: the cycle after RESP is always IDLE, so a valid still high there is a new request. The LSU clears its valid on the response edge, so no double acceptance occurs.
- Error conditions, evaluated at acceptance:
  - size>2
  - len!=0
  - misalignment: half with addr[0]=1, or word with addr[1:0]!=0
  - address out of range: word index = (addr-BASE_ADDR)>>2, valid only when index < DEPTH_WORDS and addr>=BASE_ADDR
- On error: no array access, read data 0, resp_err_o=1 for the response cycle, and latency is unchanged.
- Read path:
  - Read the word at acceptance and shift right by 8*addr[1:0].
  - Mask to size (byte: [7:0], half: [15:0]); upper bits are 0, and the LSU performs sign extension.
- Write path:
  - Shift data left by 8*addr[1:0].
  - Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - The array write commits on the acceptance edge, so a read accepted afterwards sees the new data.
- Address arithmetic: 32-bit subtraction; wrap below BASE_ADDR is detected as out of range.

Decomposition:
- Shared define file:
  - size codes SIZE_B/H/W (0/1/2)
  - FSM state encoding (2 bits)
  - LATENCY counter width (4)
- Sub-module ysyx_23060077_lsu_lane_align: purely combinational. Takes addr[1:0], size, wdata and rdata_word. Produces the shifted wdata, the 4-bit strobe, the right-justified masked rdata and the misalign flag. It is reused later by the AXI bridge.

Test Plan:
1. Word read/write, LATENCY=2: write 0xDEADBEEF to 0x8000_0010 size 2 -> w_ready/w_last pulse at t+2, err=0. Then read 0x8000_0010 -> r_data=0xDEADBEEF at t+2, one-cycle pulse.
2. Byte/half lanes: write byte 0xAA at 0x8000_0013 over word 0x11223344 -> word becomes 0xAA223344. Read half at 0x8000_0012 -> 0x0000AA22. Read byte at 0x8000_0011 -> 0x00000033.
3. Misalign and range: read word at 0x8000_0002 -> err=1, data=0, no array change. Write at 0x7FFF_FFFC and at BASE+4*DEPTH -> err=1, memory unchanged.
4. Simultaneous valids: r_valid and w_valid both high -> read served first (pulse at t+2). Write accepted in the following IDLE cycle, response at t+3+2.
5. Latency sweep: LATENCY=1 and 15 -> pulse exactly at t+1 and t+15. Valid held high after the pulse -> reaccepted only after one IDLE cycle.
6. Reset in WAIT: write accepted, reset=0 one cycle later -> no ready/last pulse, outputs 0. Data is committed; a later read returns the written value.
